// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - opcodes, tag width and entry type shared by the reservation station
package reservation_station_pkg;

    localparam int TAG_W = 3;
    localparam int XLEN  = 32;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_BEQ   = 5'd10;
    localparam logic [4:0] OP_BNE   = 5'd11;
    localparam logic [4:0] OP_BLT   = 5'd12;
    localparam logic [4:0] OP_BGE   = 5'd13;
    localparam logic [4:0] OP_BLTU  = 5'd14;
    localparam logic [4:0] OP_BGEU  = 5'd15;
    localparam logic [4:0] OP_JALR  = 5'd16;
    localparam logic [4:0] OP_JAL   = 5'd17;
    localparam logic [4:0] OP_JAL_C = 5'd26;

    // Load/store opcodes belong to the load/store unit and are never accepted here
    localparam logic [4:0] OP_MEM_FIRST = 5'b10010;
    localparam logic [4:0] OP_MEM_LAST  = 5'b11001;
    localparam logic [4:0] NOP_OP       = 5'b11111;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic            busy;
        logic [4:0]      op;
        logic [XLEN-1:0] vj;
        logic [XLEN-1:0] vk;
        logic [XLEN-1:0] imm;
        tag_t            qj;
        tag_t            qk;
        tag_t            dest;
    } rs_entry_t;

    function automatic rs_entry_t rs_wake(rs_entry_t e, tag_t tag_a, logic [XLEN-1:0] val_a,
                                          tag_t tag_b, logic [XLEN-1:0] val_b);
        rs_entry_t r;
        r = e;
        if (tag_a != '0 && r.qj == tag_a) begin r.vj = val_a; r.qj = '0; end
        if (tag_a != '0 && r.qk == tag_a) begin r.vk = val_a; r.qk = '0; end
        if (tag_b != '0 && r.qj == tag_b) begin r.vj = val_b; r.qj = '0; end
        if (tag_b != '0 && r.qk == tag_b) begin r.vk = val_b; r.qk = '0; end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - dispatch bundle, load broadcast and result/stall signals of the reservation station
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic [4:0]      op_in;
    logic [XLEN-1:0] value1_in;
    logic [XLEN-1:0] value2_in;
    logic [XLEN-1:0] imm_in;
    tag_t            query1_in;
    tag_t            query2_in;
    tag_t            target_in;
    tag_t            mem_num;
    logic [XLEN-1:0] mem_value;
    logic            rs_full;
    tag_t            alu_num;
    logic [XLEN-1:0] alu_value;

    modport master (
        output op_in, value1_in, value2_in, imm_in, query1_in, query2_in, target_in,
        output mem_num, mem_value,
        input  rs_full, alu_num, alu_value
    );

    modport slave (
        input  op_in, value1_in, value2_in, imm_in, query1_in, query2_in, target_in,
        input  mem_num, mem_value,
        output rs_full, alu_num, alu_value
    );
endinterface

// File: rtl/reservation_station_alu.sv
// rtl/reservation_station_alu.sv - combinational integer ALU executing one selected entry
module rs_alu
    import reservation_station_pkg::*;
(
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:           result = a + b;
            OP_SUB:           result = a - b;
            OP_AND:           result = a & b;
            OP_OR:            result = a | b;
            OP_XOR:           result = a ^ b;
            OP_SLL:           result = a << b[4:0];
            OP_SRL:           result = a >> b[4:0];
            OP_SRA:           result = $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:           result = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU:          result = {31'b0, a < b};
            OP_BEQ:           result = {31'b0, a == b};
            OP_BNE:           result = {31'b0, a != b};
            OP_BLT:           result = {31'b0, $signed(a) < $signed(b)};
            OP_BGE:           result = {31'b0, $signed(a) >= $signed(b)};
            OP_BLTU:          result = {31'b0, a < b};
            OP_BGEU:          result = {31'b0, a >= b};
            OP_JALR:          result = (a + b) & ~32'd1;
            OP_JAL, OP_JAL_C: result = b;
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU reservation station: capture, operand wakeup, oldest-slot-first issue
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    reservation_station_if.slave rs
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t       ent_q [DEPTH];
    rs_entry_t       ent_d [DEPTH];
    tag_t            alu_num_q,   alu_num_d;
    logic [XLEN-1:0] alu_value_q, alu_value_d;
    logic            rs_full_q,   rs_full_d;

    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic [4:0]       sel_op;
    logic [XLEN-1:0]  sel_a;
    logic [XLEN-1:0]  sel_b;
    tag_t             sel_dest;
    logic             free_valid;
    logic [IDX_W-1:0] free_idx;
    logic             disp_ok;
    logic             accept;
    logic [XLEN-1:0]  alu_res;
    logic [CNT_W-1:0] busy_cnt;
    logic             unused_imm;

    // Descending scan so the lowest index wins for both issue and allocation
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        sel_op     = NOP_OP;
        sel_a      = '0;
        sel_b      = '0;
        sel_dest   = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].busy && ent_q[i].qj == '0 && ent_q[i].qk == '0) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_op    = ent_q[i].op;
                sel_a     = ent_q[i].vj;
                sel_b     = ent_q[i].vk;
                sel_dest  = ent_q[i].dest;
            end
            if (!ent_q[i].busy) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign disp_ok = (rs.op_in != NOP_OP) && (rs.target_in != '0) &&
                     !((rs.op_in >= OP_MEM_FIRST) && (rs.op_in <= OP_MEM_LAST));
    // Free slots come from the pre-edge state: a slot issuing this edge is not reusable yet
    assign accept  = disp_ok && free_valid;

    rs_alu u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_res)
    );

    always_comb begin
        busy_cnt   = '0;
        unused_imm = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (sel_valid && sel_idx == IDX_W'(i)) begin
                ent_d[i].busy = 1'b0;
            end
            if (accept && free_idx == IDX_W'(i)) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].op   = rs.op_in;
                ent_d[i].vj   = rs.value1_in;
                ent_d[i].vk   = rs.value2_in;
                ent_d[i].imm  = rs.imm_in;
                ent_d[i].qj   = rs.query1_in;
                ent_d[i].qk   = rs.query2_in;
                ent_d[i].dest = rs.target_in;
            end
            // Wakeup after dispatch so a fresh entry also catches a live broadcast
            if (ent_d[i].busy) begin
                ent_d[i] = rs_wake(ent_d[i], rs.mem_num, rs.mem_value, alu_num_q, alu_value_q);
            end
            busy_cnt   = busy_cnt + CNT_W'(ent_d[i].busy);
            unused_imm = unused_imm ^ (^ent_q[i].imm);
        end
        rs_full_d   = busy_cnt >= CNT_W'(DEPTH - 1);
        alu_num_d   = sel_valid ? sel_dest : '0;
        alu_value_d = sel_valid ? alu_res : alu_value_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alu_num_q   <= '0;
            alu_value_q <= '0;
            rs_full_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            alu_num_q   <= alu_num_d;
            alu_value_q <= alu_value_d;
            rs_full_q   <= rs_full_d;
        end
    end

    assign rs.alu_num   = alu_num_q;
    assign rs.alu_value = alu_value_q;
    assign rs.rs_full   = rs_full_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed and random checks of reservation_station against a slot-level model
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reservation_station_if rif();

    reservation_station #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (rif)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          busy;
        logic [4:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [2:0]  qj;
        logic [2:0]  qk;
        logic [2:0]  dest;
    } slot_t;

    slot_t       slots [DEPTH];
    logic [2:0]  m_num;
    logic [31:0] m_val;
    bit          m_full;

    function automatic logic [31:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] sa;
        logic [31:0] sb;
        logic [63:0] ext;
        int          sh;
        sa  = a ^ 32'h8000_0000;
        sb  = b ^ 32'h8000_0000;
        sh  = int'(b % 32);
        ext = {{32{a[31]}}, a} >> sh;
        case (op)
            OP_ADD:           return a + b;
            OP_SUB:           return a + ~b + 32'd1;
            OP_AND:           return a & b;
            OP_OR:            return a | b;
            OP_XOR:           return a ^ b;
            OP_SLL:           return a << sh;
            OP_SRL:           return a >> sh;
            OP_SRA:           return ext[31:0];
            OP_SLT, OP_BLT:   return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU, OP_BLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_BEQ:           return (a == b) ? 32'd1 : 32'd0;
            OP_BNE:           return (a != b) ? 32'd1 : 32'd0;
            OP_BGE:           return (sa >= sb) ? 32'd1 : 32'd0;
            OP_BGEU:          return (a >= b) ? 32'd1 : 32'd0;
            OP_JALR:          return (a + b) & 32'hFFFF_FFFE;
            OP_JAL, OP_JAL_C: return b;
            default:          return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) slots[i].busy = 1'b0;
        m_num  = 3'd0;
        m_val  = 32'd0;
        m_full = 1'b0;
    endtask

    // Advances the model across one rising edge using the inputs currently driven
    task automatic model_step();
        slot_t       nxt [DEPTH];
        int          pick;
        int          cnt;
        bit          take;
        bit          placed;
        logic [2:0]  n_num;
        logic [31:0] n_val;
        nxt    = slots;
        pick   = -1;
        cnt    = 0;
        placed = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (pick < 0 && slots[i].busy && slots[i].qj == 3'd0 && slots[i].qk == 3'd0) pick = i;
        n_num = 3'd0;
        n_val = m_val;
        if (pick >= 0) begin
            n_num = slots[pick].dest;
            n_val = ref_alu(slots[pick].op, slots[pick].vj, slots[pick].vk);
            nxt[pick].busy = 1'b0;
        end
        take = rif.op_in != NOP_OP && rif.target_in != 3'd0 && !(rif.op_in inside {[5'd18:5'd25]});
        for (int i = 0; i < DEPTH; i++) begin
            if (take && !placed && !slots[i].busy) begin
                placed       = 1'b1;
                nxt[i].busy  = 1'b1;
                nxt[i].op    = rif.op_in;
                nxt[i].vj    = rif.value1_in;
                nxt[i].vk    = rif.value2_in;
                nxt[i].qj    = rif.query1_in;
                nxt[i].qk    = rif.query2_in;
                nxt[i].dest  = rif.target_in;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (nxt[i].busy) begin
                if (rif.mem_num != 3'd0 && nxt[i].qj == rif.mem_num) begin nxt[i].vj = rif.mem_value; nxt[i].qj = 3'd0; end
                if (rif.mem_num != 3'd0 && nxt[i].qk == rif.mem_num) begin nxt[i].vk = rif.mem_value; nxt[i].qk = 3'd0; end
                if (m_num != 3'd0 && nxt[i].qj == m_num) begin nxt[i].vj = m_val; nxt[i].qj = 3'd0; end
                if (m_num != 3'd0 && nxt[i].qk == m_num) begin nxt[i].vk = m_val; nxt[i].qk = 3'd0; end
                cnt++;
            end
        end
        slots  = nxt;
        m_num  = n_num;
        m_val  = n_val;
        m_full = (cnt >= DEPTH - 1);
    endtask

    task automatic idle();
        rif.op_in     = NOP_OP;
        rif.value1_in = 32'd0;
        rif.value2_in = 32'd0;
        rif.imm_in    = 32'd0;
        rif.query1_in = 3'd0;
        rif.query2_in = 3'd0;
        rif.target_in = 3'd0;
        rif.mem_num   = 3'd0;
        rif.mem_value = 32'd0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [2:0] q1, input logic [2:0] q2, input logic [2:0] tgt);
        idle();
        rif.op_in     = op;
        rif.value1_in = v1;
        rif.value2_in = v2;
        rif.imm_in    = $urandom;
        rif.query1_in = q1;
        rif.query2_in = q2;
        rif.target_in = tgt;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_eq("alu_num", 32'(rif.alu_num), 32'(m_num));
        check_eq("alu_value", rif.alu_value, m_val);
        check_eq("rs_full", 32'(rif.rs_full), 32'(m_full));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [4:0] op;
        idle();
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_num", 32'(rif.alu_num), 32'd0);
        check_eq("reset_val", rif.alu_value, 32'd0);
        check_eq("reset_full", 32'(rif.rs_full), 32'd0);
        rst = 1'b1;

        disp(OP_ADD, 32'd3, 32'd4, 3'd0, 3'd0, 3'd2); tick();
        idle(); tick();
        check_eq("add_num", 32'(rif.alu_num), 32'd2);
        check_eq("add_val", rif.alu_value, 32'd7);
        tick();
        check_eq("add_once", 32'(rif.alu_num), 32'd0);

        disp(OP_SUB, 32'd0, 32'd1, 3'd3, 3'd0, 3'd4); tick();
        idle(); rif.mem_num = 3'd3; rif.mem_value = 32'd10; tick();
        idle(); tick();
        check_eq("sub_num", 32'(rif.alu_num), 32'd4);
        check_eq("sub_val", rif.alu_value, 32'd9);

        disp(OP_BLT, 32'hFFFF_FFFF, 32'd1, 3'd0, 3'd0, 3'd1); tick();
        disp(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 3'd0, 3'd0, 3'd2); tick();
        check_eq("blt_val", rif.alu_value, 32'd1);
        disp(OP_JALR, 32'h1001, 32'd4, 3'd0, 3'd0, 3'd3); tick();
        check_eq("bltu_val", rif.alu_value, 32'd0);
        idle(); tick();
        check_eq("jalr_val", rif.alu_value, 32'h1004);

        for (int k = 1; k <= 4; k++) begin
            disp(OP_ADD, 32'd0, 32'(10 * k), 3'd7, 3'd0, 3'(k)); tick();
            check_eq("full_fill", 32'(rif.rs_full), (k >= 3) ? 32'd1 : 32'd0);
        end
        disp(OP_ADD, 32'd1, 32'd1, 3'd0, 3'd0, 3'd5); tick();
        check_eq("drop_none", 32'(rif.alu_num), 32'd0);
        idle(); rif.mem_num = 3'd7; rif.mem_value = 32'd100; tick();
        for (int k = 1; k <= 4; k++) begin
            idle(); tick();
            check_eq("order_num", 32'(rif.alu_num), 32'(k));
            check_eq("order_val", rif.alu_value, 32'(100 + 10 * k));
        end
        check_eq("full_fall", 32'(rif.rs_full), 32'd0);
        idle(); tick();
        check_eq("drop_gone", 32'(rif.alu_num), 32'd0);

        disp(OP_ADD, 32'd0, 32'd1, 3'd5, 3'd0, 3'd6);
        rif.mem_num = 3'd5; rif.mem_value = 32'd20; tick();
        idle(); tick();
        check_eq("bypass_num", 32'(rif.alu_num), 32'd6);
        check_eq("bypass_val", rif.alu_value, 32'd21);

        disp(OP_ADD, 32'd1, 32'd2, 3'd0, 3'd0, 3'd1); tick();
        disp(OP_OR, 32'd0, 32'd8, 3'd1, 3'd0, 3'd2); tick();
        idle(); tick(); tick();
        check_eq("chain_num", 32'(rif.alu_num), 32'd2);
        check_eq("chain_val", rif.alu_value, 32'd11);

        disp(OP_ADD, 32'd1, 32'd2, 3'd0, 3'd0, 3'd1); tick();
        disp(OP_OR, 32'd0, 32'd8, 3'd1, 3'd0, 3'd2); tick();
        idle();
        #2 rst = 1'b0;
        #1;
        check_eq("rst_num", 32'(rif.alu_num), 32'd0);
        check_eq("rst_val", rif.alu_value, 32'd0);
        check_eq("rst_full", 32'(rif.rs_full), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("rst_no_late", 32'(rif.alu_num), 32'd0);
        end

        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 7) begin
                    r  = $urandom_range(0, 18);
                    op = (r == 18) ? OP_JAL_C : 5'(r);
                end else if (r == 7) op = NOP_OP;
                else if (r == 8) op = 5'($urandom_range(18, 25));
                else op = 5'($urandom_range(26, 30));
                disp(op,
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                     ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
                     ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
                     3'($urandom_range(0, 7)));
                if ($urandom_range(0, 7) == 0) rif.value2_in = rif.value1_in;
            end
            if ($urandom_range(0, 1) == 0) begin
                rif.mem_num   = 3'($urandom_range(1, 7));
                rif.mem_value = $urandom;
                if (rif.mem_num == m_num) rif.mem_num = 3'd0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Dispatch-side receiver for the reorder buffer's issue port, paired with a single-cycle integer ALU. It captures one ALU-class instruction per cycle from the ROB's operand/tag bundle and holds it until both operands are resolved. Operands resolve from the result broadcasts (`alu_num`/`alu_value` from this block, `mem_num`/`mem_value` from the load/store unit). It then executes the instruction and broadcasts the result tag and value back to the ROB. It drives `rs_full` to stall ROB issue.

## Interface
- `DEPTH`, default 4: number of entries, 2..8.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `op_in`  in  5: opcode. `5'b11111` means no dispatch.
- `value1_in`, `value2_in`  in  32 each: operand values. `value2_in` already holds the immediate when the instruction uses one.
- `query1_in`, `query2_in`  in  3 each: producer ROB tag for each operand. 0 means the value is valid.
- `imm_in`  in  32: raw immediate. Captured but unused by the ALU (reserved).
- `target_in`  in  3: destination ROB tag, 1..7.
- `mem_num`  in  3: load-result broadcast tag. 0 means none.
- `mem_value`  in  32: load-result broadcast value.
- `rs_full`  out  1: registered stall to the ROB.
- `alu_num`  out  3: result tag. 0 means no result this cycle.
- `alu_value`  out  32: result value.

## Operation
- **Dispatch.** An instruction is accepted when `op_in != 11111` and `target_in != 0`. It is written into the lowest-index free entry: busy=1, op, vj/vk, qj/qk, dest.
  - Load/store opcodes `10010`..`11001` are never accepted; they belong to the load/store unit.
- **Wakeup.** Any busy entry with `qj` (or `qk`) equal to a nonzero broadcast tag captures that broadcast's value and clears the tag.
  - Broadcast sources: `mem_num` and this block's own registered `alu_num`.
  - Both broadcasts act in the same cycle.
  - The same wakeup applies to operands arriving on dispatch in the same cycle (bypass): a `query*_in` that matches a live broadcast is stored as tag 0 with the broadcast value.
- **Issue.** Each cycle, the lowest-index entry that is busy with qj=qk=0 is selected.
  - The ALU result is computed combinationally.
  - `alu_num`/`alu_value` are registered on that edge and the entry is freed.
  - With no ready entry, `alu_num` is 0; `alu_value` holds its last value.
- **ALU.** A=vj, B=vk.
  - ADD: A+B. SUB: A−B. AND, OR, XOR: bitwise.
  - SLL/SRL/SRA: shift by B[4:0].
  - SLT: signed less-than; SLTU: unsigned less-than. Result is 1 or 0.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU: condition result, 1=taken, 0=not taken.
  - JALR: (A+B) & ~1.
  - JAL, JAL_C: B (the offset).
  - Any other opcode: 0.
  - All arithmetic is 32-bit modulo.
- **Full handling.** `rs_full` is registered high when the busy count after the edge is ≥ DEPTH−1. This gives one cycle of slack for a dispatch already in flight. A dispatch that arrives with all entries busy is dropped.

## Timing
- Reset values: all busy=0, `alu_num`=0, `alu_value`=0, `rs_full`=0. Reset takes effect immediately and abandons in-flight entries.
- Latency when operands are ready at dispatch:
  - Captured at edge N.
  - Eligible for selection at edge N+1.
  - `alu_num` is valid in the cycle after edge N+1 and lasts exactly one cycle per result.
- Wakeup latency: a broadcast visible in cycle C makes the waiting entry eligible at the edge ending cycle C+1. There is no same-edge wake-and-issue.
- Order of operations within one edge: issue-free, dispatch, then wakeup. An entry freed at edge N can be reallocated at edge N+1, not at N.
- One dispatch, one issue and two broadcasts in the same cycle are all legal.

## Structure
- The shared package holds:
  - the 5-bit opcode localparams (ADD..JAL_C);
  - `NOP_OP = 5'b11111`;
  - `TAG_W = 3`.
- Sub-module `rs_alu`: purely combinational, taking op, A and B and producing a 32-bit result.
- Entry storage, select logic and wakeup stay in `reservation_station`.

## Test plan
- Dispatch ADD with vj=3, vk=4, tags 0, target 2 → `alu_num`=2 and `alu_value`=7 one cycle later, then `alu_num`=0.
- Dispatch SUB with qj=3, vk=1, target 4; pulse `mem_num`=3 with `mem_value`=10 → `alu_num`=4, `alu_value`=9 two cycles after the pulse.
- Dispatch BLT with vj=0xFFFFFFFF, vk=1 → 1. Dispatch BLTU with the same operands → 0. JALR with vj=0x1001, vk=4 → 0x1004.
- Dispatch four entries all waiting on tag 7 → `rs_full` rises after the third capture and all four are accepted. `mem_num`=7 → results issue lowest-index first on four consecutive cycles, and `rs_full` falls.
- Dispatch with `query1_in`=5 in the same cycle as `mem_num`=5, `mem_value`=20, and vk=1 on ADD → result 21 with no further broadcast needed.
- Chain: ADD target 1 → OR with qj=1 target 2 resolves from the block's own `alu_num`. Assert `rst` low mid-chain → outputs 0 immediately and no later result appears.
